hazard_scoreboard: RTL and testbench

Parametrised, stateful successor to the combinational ID-stage hazard detector. It keeps a per-register scoreboard of countdown timers, loaded when a writing instruction issues from ID. It raises hazard_detected when an ID-stage source register is still unavailable. Availability is judged in one of two modes: forwarding (load-use distance) or no forwarding (writeback distance). It also honours a pipeline freeze and a flush, and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_scoreboard.sv | 112 +++++++++++
 tb/tb_hazard_scoreboard.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register countdown timers decide whether a
// source operand is still in flight, in forwarding or non-forwarding mode.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int WB_DIST    = 2,
  parameter int LOAD_DIST  = 1,
  parameter int STAT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_forward,
  input  logic                  id_valid,
  input  logic                  single_source,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_rd_en,
  input  logic                  freeze,
  input  logic                  flush,
  output logic                  hazard_detected,
  output logic [STAT_W-1:0]     stall_count
);

  localparam int         NUM_REGS = 2 ** REG_ADDR_W;
  localparam logic [3:0] WB_LOAD  = 4'(WB_DIST);
  localparam logic [3:0] LD_LOAD  = 4'(LOAD_DIST);

  logic [3:0]          wb_cnt_reg [NUM_REGS];
  logic [3:0]          ld_cnt_reg [NUM_REGS];
  logic [NUM_REGS-1:0] wb_busy;
  logic [NUM_REGS-1:0] ld_busy;
  logic                issue;
  logic                src1_busy;
  logic                src2_busy;
  logic [STAT_W-1:0]   stall_count_reg;
  logic [STAT_W-1:0]   stall_count_next;

  assign issue = id_valid & ~hazard_detected & ~freeze & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // r0 is hard-wired: never tracked, never busy.
        always_ff @(posedge clk) begin
          wb_cnt_reg[gi] <= 4'd0;
          ld_cnt_reg[gi] <= 4'd0;
        end
        assign wb_busy[gi] = 1'b0;
        assign ld_busy[gi] = 1'b0;
      end else begin : g_track
        logic       hit;
        logic [3:0] wb_dec;
        logic [3:0] ld_dec;
        logic [3:0] ld_floor;
        logic [3:0] wb_next;
        logic [3:0] ld_next;

        assign hit = issue & id_wb_en & (id_dest == REG_ADDR_W'(gi));

        always_comb begin
          wb_dec   = (wb_cnt_reg[gi] != 4'd0) ? wb_cnt_reg[gi] - 4'd1 : 4'd0;
          ld_dec   = (ld_cnt_reg[gi] != 4'd0) ? ld_cnt_reg[gi] - 4'd1 : 4'd0;
          ld_floor = id_rd_en ? LD_LOAD : 4'd0;
          wb_next  = wb_dec;
          ld_next  = ld_dec;
          // A new writer never shortens an older writer's remaining window.
          if (hit) begin
            wb_next = (wb_dec > WB_LOAD) ? wb_dec : WB_LOAD;
            ld_next = (ld_dec > ld_floor) ? ld_dec : ld_floor;
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            wb_cnt_reg[gi] <= 4'd0;
            ld_cnt_reg[gi] <= 4'd0;
          end else if (!freeze) begin
            wb_cnt_reg[gi] <= wb_next;
            ld_cnt_reg[gi] <= ld_next;
          end
        end

        assign wb_busy[gi] = (wb_cnt_reg[gi] != 4'd0);
        assign ld_busy[gi] = (ld_cnt_reg[gi] != 4'd0);
      end
    end
  endgenerate

  always_comb begin
    src1_busy       = is_forward ? ld_busy[src1] : wb_busy[src1];
    src2_busy       = is_forward ? ld_busy[src2] : wb_busy[src2];
    hazard_detected = id_valid & ~flush & (src1_busy | (~single_source & src2_busy));
  end

  always_comb begin
    stall_count_next = stall_count_reg;
    if (id_valid && hazard_detected && !freeze && (stall_count_reg != {STAT_W{1'b1}}))
      stall_count_next = stall_count_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_count_reg <= '0;
    else
      stall_count_reg <= stall_count_next;
  end

  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a timestamp-based reference model
// (each register remembers the active-cycle at which its value becomes usable).
module tb_hazard_scoreboard;
  localparam int AW = 5;
  localparam int SW = 4;
  localparam int WB_DIST = 2;
  localparam int LOAD_DIST = 1;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          is_forward = 1'b0;
  logic          id_valid = 1'b0;
  logic          single_source = 1'b0;
  logic [AW-1:0] src1 = '0;
  logic [AW-1:0] src2 = '0;
  logic [AW-1:0] id_dest = '0;
  logic          id_wb_en = 1'b0;
  logic          id_rd_en = 1'b0;
  logic          freeze = 1'b0;
  logic          flush = 1'b0;
  logic          hazard_detected;
  logic [SW-1:0] stall_count;

  int tests = 0;
  int fails = 0;

  hazard_scoreboard #(
    .REG_ADDR_W(AW), .WB_DIST(WB_DIST), .LOAD_DIST(LOAD_DIST), .STAT_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .is_forward(is_forward), .id_valid(id_valid),
    .single_source(single_source), .src1(src1), .src2(src2), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_rd_en(id_rd_en), .freeze(freeze), .flush(flush),
    .hazard_detected(hazard_detected), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Model: a value is usable once the count of unfrozen edges reaches its ready time.
  int active = 0;
  int wb_ready [32];
  int ld_ready [32];
  int m_stall = 0;

  initial begin
    for (int r = 0; r < 32; r++) begin
      wb_ready[r] = 0;
      ld_ready[r] = 0;
    end
  end

  function automatic logic m_busy(input int r);
    if (r == 0) return 1'b0;
    return is_forward ? (active < ld_ready[r]) : (active < wb_ready[r]);
  endfunction

  function automatic logic m_hazard();
    return id_valid && !flush &&
           (m_busy(int'(src1)) || (!single_source && m_busy(int'(src2))));
  endfunction

  always @(posedge clk) begin
    logic hz;
    int   d;
    hz = m_hazard();
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        wb_ready[r] = 0;
        ld_ready[r] = 0;
      end
      m_stall = 0;
    end else if (!freeze) begin
      if (id_valid && hz && m_stall < SAT) m_stall = m_stall + 1;
      if (id_valid && !hz && !flush && id_wb_en && id_dest != 0) begin
        d = int'(id_dest);
        if (wb_ready[d] < active + 1 + WB_DIST) wb_ready[d] = active + 1 + WB_DIST;
        if (ld_ready[d] < active + 1 + (id_rd_en ? LOAD_DIST : 0))
          ld_ready[d] = active + 1 + (id_rd_en ? LOAD_DIST : 0);
      end
      active = active + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (hazard_detected !== m_hazard() || int'(stall_count) != m_stall) begin
        fails++;
        $display("FAIL model t=%0t: got hz=%0b cnt=%0d, want hz=%0b cnt=%0d",
                 $time, hazard_detected, stall_count, m_hazard(), m_stall);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input int s1, input int s2, input logic ss, input int dest,
                       input logic wb, input logic rd);
    id_valid = 1'b1; src1 = AW'(s1); src2 = AW'(s2); single_source = ss;
    id_dest = AW'(dest); id_wb_en = wb; id_rd_en = rd;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_wb_en = 1'b0; id_rd_en = 1'b0;
  endtask

  // Literal check in the current cycle, sampled at the falling edge.
  task automatic chk(input string name, input logic exp_hz, input int exp_cnt);
    @(negedge clk);
    tests++;
    if (hazard_detected !== exp_hz || int'(stall_count) != exp_cnt) begin
      fails++;
      $display("FAIL %s: got hz=%0b cnt=%0d, want hz=%0b cnt=%0d",
               name, hazard_detected, stall_count, exp_hz, exp_cnt);
    end
    $display("[TB] %s hz=%0b cnt=%0d", name, hazard_detected, stall_count);
    tick();
  endtask

  task automatic do_reset();
    idle(); freeze = 1'b0; flush = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    tick();
    do_reset();
    chk("reset_state", 1'b0, 0);

    // No-forward RAW on r3
    is_forward = 1'b0;
    instr(1, 2, 1'b0, 3, 1'b1, 1'b0); chk("nf_producer", 1'b0, 0);
    instr(3, 1, 1'b0, 4, 1'b1, 1'b0); chk("nf_t1", 1'b1, 0);
    chk("nf_t2", 1'b1, 1);
    chk("nf_t3", 1'b0, 2);
    idle(); chk("nf_after", 1'b0, 2);

    // Forwarding: ALU producer then load producer on r5
    do_reset(); is_forward = 1'b1;
    instr(1, 2, 1'b0, 5, 1'b1, 1'b0); chk("fw_alu_prod", 1'b0, 0);
    instr(5, 1, 1'b0, 4, 1'b1, 1'b0); chk("fw_alu_cons", 1'b0, 0);
    instr(1, 2, 1'b0, 5, 1'b1, 1'b1); chk("fw_lw_prod", 1'b0, 0);
    instr(5, 1, 1'b0, 4, 1'b1, 1'b0); chk("fw_lw_t1", 1'b1, 0);
    chk("fw_lw_t2", 1'b0, 1);
    idle(); chk("fw_idle", 1'b0, 1);

    // r0 and single_source
    do_reset(); is_forward = 1'b0;
    instr(1, 2, 1'b0, 0, 1'b1, 1'b0); chk("r0_prod", 1'b0, 0);
    instr(0, 0, 1'b0, 4, 1'b0, 1'b0); chk("r0_cons", 1'b0, 0);
    instr(1, 2, 1'b0, 7, 1'b1, 1'b0); chk("r7_prod", 1'b0, 0);
    instr(1, 7, 1'b1, 4, 1'b0, 1'b0); chk("ss_one", 1'b0, 0);
    instr(1, 7, 1'b0, 4, 1'b0, 1'b0); chk("ss_zero", 1'b1, 0);
    chk("ss_zero_clear", 1'b0, 1);
    idle(); tick();

    // Freeze holding a load window
    do_reset(); is_forward = 1'b1;
    instr(1, 3, 1'b0, 2, 1'b1, 1'b1); chk("frz_lw", 1'b0, 0);
    instr(2, 3, 1'b0, 4, 1'b1, 1'b0); freeze = 1'b1;
    chk("frz_t1", 1'b1, 0);
    chk("frz_t2", 1'b1, 0);
    chk("frz_t3", 1'b1, 0);
    freeze = 1'b0; chk("frz_t4", 1'b1, 0);
    chk("frz_t5", 1'b0, 1);
    idle(); tick();

    // Flush suppresses issue and hazard
    do_reset(); is_forward = 1'b0;
    instr(1, 2, 1'b0, 9, 1'b1, 1'b0); flush = 1'b1; chk("fl_add_r9", 1'b0, 0);
    flush = 1'b0;
    instr(9, 9, 1'b0, 4, 1'b0, 1'b0); chk("fl_cons_r9", 1'b0, 0);
    instr(1, 2, 1'b0, 8, 1'b1, 1'b0); chk("fl_prod_r8", 1'b0, 0);
    instr(8, 1, 1'b0, 4, 1'b0, 1'b0); flush = 1'b1; chk("fl_cons_r8", 1'b0, 0);
    flush = 1'b0; chk("fl_r8_after", 1'b1, 0);
    idle(); tick(); tick();

    // Back-to-back writers of r6
    do_reset(); is_forward = 1'b0;
    instr(1, 2, 1'b0, 6, 1'b1, 1'b0); chk("b2b_w1", 1'b0, 0);
    instr(1, 2, 1'b0, 6, 1'b1, 1'b0); chk("b2b_w2", 1'b0, 0);
    instr(6, 1, 1'b0, 4, 1'b0, 1'b0); chk("b2b_t1", 1'b1, 0);
    chk("b2b_t2", 1'b1, 1);
    chk("b2b_t3", 1'b0, 2);
    idle(); tick();

    // Saturation: r10 <- r10 stalls two of every three cycles
    do_reset(); is_forward = 1'b0;
    instr(1, 2, 1'b0, 10, 1'b1, 1'b0); tick();
    instr(10, 10, 1'b0, 10, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) tick();
    chk("sat_hold", 1'b1, SAT);

    // Reset with busy counters, under freeze and flush
    instr(1, 2, 1'b0, 10, 1'b1, 1'b0); tick();
    instr(10, 10, 1'b0, 4, 1'b0, 1'b0); rst = 1'b1; freeze = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    chk("rst_clears", 1'b0, 0);
    idle(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end
endmodule
